// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS burst sequencer and its config shadow.
package prbs_pkg;

  // Sequencer states; the encoding is visible on the debug state output.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESEED = 3'd1,
    ST_RUN    = 3'd2,
    ST_GAP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  localparam int PN_SEL_W    = 4;
  localparam int BIT_RATE_W  = 32;
  localparam int EDGE_TIME_W = 8;

  localparam int DEFAULT_RESEED_CYCLES = 4;

  // PN select codes understood by the downstream generator.
  localparam logic [PN_SEL_W-1:0] PN_7  = 4'd0;
  localparam logic [PN_SEL_W-1:0] PN_9  = 4'd1;
  localparam logic [PN_SEL_W-1:0] PN_11 = 4'd2;
  localparam logic [PN_SEL_W-1:0] PN_15 = 4'd3;
  localparam logic [PN_SEL_W-1:0] PN_20 = 4'd4;
  localparam logic [PN_SEL_W-1:0] PN_23 = 4'd5;
  localparam logic [PN_SEL_W-1:0] PN_31 = 4'd6;

  // One complete generator configuration.
  typedef struct packed {
    logic [PN_SEL_W-1:0]    pn_select;
    logic [BIT_RATE_W-1:0]  bit_rate;
    logic [EDGE_TIME_W-1:0] edge_time;
  } cfg_t;

  // True while the generator is owned by a run (reseeding, bursting or gapping).
  function automatic logic is_busy(input state_e s);
    return (s == ST_RESEED) || (s == ST_RUN) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/prbs_burst_sequencer_if.sv
// Control/status bundle between channel software logic and the burst sequencer.
//
// Signalling: there is no valid/ready handshake here. cfg_wr, start, stop and
// fault_clr are single-cycle strobes sampled on every dac_clk rising edge and
// always accepted (their effect depends on the current state); the level inputs
// (burst_len, gap_len, burst_total, reseed_each, protect, lfsr_clk_enable) are
// sampled every edge. All outputs, including the debug state, are registered.
interface prbs_burst_sequencer_if #(
  parameter int LEN_W   = 32,
  parameter int BURST_W = 16
);
  import prbs_pkg::*;

  logic                   cfg_wr;
  logic [PN_SEL_W-1:0]    cfg_pn_select;
  logic [BIT_RATE_W-1:0]  cfg_bit_rate;
  logic [EDGE_TIME_W-1:0] cfg_edge_time;
  logic [LEN_W-1:0]       burst_len;
  logic [LEN_W-1:0]       gap_len;
  logic [BURST_W-1:0]     burst_total;
  logic                   reseed_each;
  logic                   start;
  logic                   stop;
  logic                   fault_clr;
  logic                   CH_LOAD_PROTECT_STATE;
  logic                   lfsr_clk_enable;

  logic                   core_reset_n;
  logic [PN_SEL_W-1:0]    prbs_pn_select_out;
  logic [BIT_RATE_W-1:0]  prbs_bit_rate_out;
  logic [EDGE_TIME_W-1:0] prbs_edge_time_out;
  logic                   output_enable;
  logic                   busy;
  logic                   done;
  logic                   fault;
  logic                   cfg_pending;
  logic [BURST_W-1:0]     burst_idx;
  state_e                 state;

  modport master (
    output cfg_wr, cfg_pn_select, cfg_bit_rate, cfg_edge_time,
    output burst_len, gap_len, burst_total, reseed_each,
    output start, stop, fault_clr, CH_LOAD_PROTECT_STATE, lfsr_clk_enable,
    input  core_reset_n, prbs_pn_select_out, prbs_bit_rate_out, prbs_edge_time_out,
    input  output_enable, busy, done, fault, cfg_pending, burst_idx, state
  );

  modport slave (
    input  cfg_wr, cfg_pn_select, cfg_bit_rate, cfg_edge_time,
    input  burst_len, gap_len, burst_total, reseed_each,
    input  start, stop, fault_clr, CH_LOAD_PROTECT_STATE, lfsr_clk_enable,
    output core_reset_n, prbs_pn_select_out, prbs_bit_rate_out, prbs_edge_time_out,
    output output_enable, busy, done, fault, cfg_pending, burst_idx, state
  );

endinterface

// File: rtl/prbs_cfg_shadow.sv
// Staging/active configuration pair. Software writes land in staging at any
// time; the active copy only changes on a commit strobe from the sequencer.
module prbs_cfg_shadow
  import prbs_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cfg_wr,
  input  cfg_t cfg_in,
  input  logic commit,
  output cfg_t active,
  output logic pending
);

  cfg_t staging;

  // Staging capture, commit to active (write-through when a write coincides
  // with the commit), and pending flag tracking uncommitted writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      staging <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        staging <= cfg_in;
      end
      if (commit) begin
        active <= cfg_wr ? cfg_in : staging;
      end
      if (commit) begin
        pending <= 1'b0;
      end else if (cfg_wr) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/prbs_burst_sequencer.sv
// Burst sequencer in front of a channel's PRBS generator: reseeds the core,
// gates the DAC output into bursts and gaps, commits configuration only at
// burst boundaries, and latches a fault on channel load protection.
module prbs_burst_sequencer
  import prbs_pkg::*;
#(
  parameter int RESEED_CYCLES = DEFAULT_RESEED_CYCLES,
  parameter int LEN_W         = 32,
  parameter int BURST_W       = 16
) (
  input logic                   dac_clk,
  input logic                   reset,
  prbs_burst_sequencer_if.slave ctl
);

  localparam int RS_W = $clog2(RESEED_CYCLES);
  localparam logic [RS_W-1:0] RS_LAST = RS_W'(RESEED_CYCLES - 1);

  state_e             state_q;
  state_e             state_d;
  logic [RS_W-1:0]    rs_cnt_q;
  logic [LEN_W-1:0]   bit_cnt_q;
  logic [BURST_W-1:0] idx_q;

  logic commit;
  logic bit_clr;
  logic idx_clr;
  logic idx_inc;
  logic boundary;
  logic run_last;
  logic gap_last;
  logic last_burst;

  logic core_reset_n_q;
  logic output_enable_q;
  logic busy_q;
  logic done_q;
  logic fault_q;

  cfg_t cfg_in;
  cfg_t active;
  logic pending;

  assign cfg_in = '{pn_select: ctl.cfg_pn_select,
                    bit_rate:  ctl.cfg_bit_rate,
                    edge_time: ctl.cfg_edge_time};

  prbs_cfg_shadow u_shadow (
    .clk     (dac_clk),
    .rst     (reset),
    .cfg_wr  (ctl.cfg_wr),
    .cfg_in  (cfg_in),
    .commit  (commit),
    .active  (active),
    .pending (pending)
  );

  // A zero burst_len means continuous; gap_len is only compared in GAP, which
  // is never entered with gap_len == 0.
  assign run_last   = (ctl.burst_len != '0) && (bit_cnt_q == ctl.burst_len - LEN_W'(1));
  assign gap_last   = (bit_cnt_q == ctl.gap_len - LEN_W'(1));
  assign last_burst = (ctl.burst_total != '0) && ((idx_q + BURST_W'(1)) == ctl.burst_total);

  // State register.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter/commit controls; protect > stop > start > counting.
  always_comb begin
    state_d  = state_q;
    commit   = 1'b0;
    bit_clr  = 1'b0;
    idx_clr  = 1'b0;
    idx_inc  = 1'b0;
    boundary = 1'b0;

    if (ctl.CH_LOAD_PROTECT_STATE) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (ctl.fault_clr) begin
        state_d = ST_IDLE;
      end
    end else if (ctl.stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (ctl.start) begin
            state_d = ST_RESEED;
            commit  = 1'b1;
            idx_clr = 1'b1;
            bit_clr = 1'b1;
          end
        end
        ST_RESEED: begin
          if (rs_cnt_q == RS_LAST) begin
            state_d = ST_RUN;
            bit_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (ctl.lfsr_clk_enable && run_last) begin
            if (ctl.gap_len != '0) begin
              state_d = ST_GAP;
              bit_clr = 1'b1;
            end else begin
              boundary = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (ctl.lfsr_clk_enable && gap_last) begin
            boundary = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // End of a burst (and its gap): finish the run or start the next burst,
    // committing any staged config behind a fresh reseed.
    if (boundary) begin
      bit_clr = 1'b1;
      if (last_burst) begin
        state_d = ST_DONE;
      end else begin
        idx_inc = 1'b1;
        if (pending) begin
          commit  = 1'b1;
          state_d = ST_RESEED;
        end else if (ctl.reseed_each) begin
          state_d = ST_RESEED;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  // Reseed hold counter, bit-tick counter and burst index.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      rs_cnt_q  <= '0;
      bit_cnt_q <= '0;
      idx_q     <= '0;
    end else begin
      rs_cnt_q <= ((state_q == ST_RESEED) && (state_d == ST_RESEED)) ? rs_cnt_q + RS_W'(1) : '0;

      if (bit_clr || !((state_q == ST_RUN) || (state_q == ST_GAP))) begin
        bit_cnt_q <= '0;
      end else if (ctl.lfsr_clk_enable) begin
        bit_cnt_q <= bit_cnt_q + LEN_W'(1);
      end

      if (idx_clr) begin
        idx_q <= '0;
      end else if (idx_inc) begin
        idx_q <= idx_q + BURST_W'(1);
      end
    end
  end

  // Status outputs registered from the next state so they line up with it.
  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      core_reset_n_q  <= 1'b0;
      output_enable_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fault_q         <= 1'b0;
    end else begin
      core_reset_n_q  <= (state_d == ST_RUN) || (state_d == ST_GAP);
      output_enable_q <= (state_d == ST_RUN);
      busy_q          <= is_busy(state_d);
      done_q          <= (state_d == ST_DONE) && (state_q != ST_DONE);
      fault_q         <= (state_d == ST_FAULT);
    end
  end

  assign ctl.core_reset_n       = core_reset_n_q;
  assign ctl.output_enable      = output_enable_q;
  assign ctl.busy               = busy_q;
  assign ctl.done               = done_q;
  assign ctl.fault              = fault_q;
  assign ctl.cfg_pending        = pending;
  assign ctl.burst_idx          = idx_q;
  assign ctl.prbs_pn_select_out = active.pn_select;
  assign ctl.prbs_bit_rate_out  = active.bit_rate;
  assign ctl.prbs_edge_time_out = active.edge_time;
  assign ctl.state              = state_q;

endmodule

// File: tb/tb_prbs_burst_sequencer.sv
// Directed bench for prbs_burst_sequencer with a per-tick scoreboard.
module tb_prbs_burst_sequencer;
  import prbs_pkg::*;

  localparam int LEN_W   = 32;
  localparam int BURST_W = 16;
  localparam int W       = BURST_W + 1;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic mon_en   = 1'b0;
  int   tick_div = 0;

  // Expected {output_enable, burst_idx} for each bit tick seen in RUN/GAP.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;

  prbs_burst_sequencer_if #(.LEN_W(LEN_W), .BURST_W(BURST_W)) ctl ();

  prbs_burst_sequencer #(
    .RESEED_CYCLES (4),
    .LEN_W         (LEN_W),
    .BURST_W       (BURST_W)
  ) dut (
    .dac_clk (clk),
    .reset   (reset),
    .ctl     (ctl)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Bit-period tick, one cycle in five.
  initial begin
    ctl.lfsr_clk_enable = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div == 4) ? 0 : tick_div + 1;
      ctl.lfsr_clk_enable = (tick_div == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected entry per tick the DUT spends in RUN or GAP.
  always @(negedge clk) begin
    if (mon_en && !reset && ctl.lfsr_clk_enable &&
        ((ctl.state == ST_RUN) || (ctl.state == ST_GAP))) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tick_extra: unexpected tick in state %0d at %0t", ctl.state, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("tick_oe", 32'(ctl.output_enable), 32'(mon_e[BURST_W]));
        chk("tick_idx", 32'(ctl.burst_idx), 32'(mon_e[BURST_W-1:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    step();
    ctl.start = 1'b1;
    step();
    ctl.start = 1'b0;
  endtask

  task automatic do_stop();
    step();
    ctl.stop = 1'b1;
    step();
    ctl.stop = 1'b0;
  endtask

  task automatic do_fault_clr();
    step();
    ctl.fault_clr = 1'b1;
    step();
    ctl.fault_clr = 1'b0;
  endtask

  task automatic do_cfg(input logic [3:0] pn, input logic [31:0] br, input logic [7:0] et);
    step();
    ctl.cfg_wr        = 1'b1;
    ctl.cfg_pn_select = pn;
    ctl.cfg_bit_rate  = br;
    ctl.cfg_edge_time = et;
    step();
    ctl.cfg_wr = 1'b0;
  endtask

  task automatic wait_state(input state_e s, input int max_cyc, input string name);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (ctl.state == s) break;
    end
    chk(name, 32'(ctl.state), 32'(s));
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(ctl.state), 32'(ST_IDLE));
    chk({tag, "_core_reset_n"}, 32'(ctl.core_reset_n), 32'd0);
    chk({tag, "_oe"}, 32'(ctl.output_enable), 32'd0);
    chk({tag, "_busy"}, 32'(ctl.busy), 32'd0);
    chk({tag, "_done"}, 32'(ctl.done), 32'd0);
    chk({tag, "_fault"}, 32'(ctl.fault), 32'd0);
    chk({tag, "_pending"}, 32'(ctl.cfg_pending), 32'd0);
    chk({tag, "_idx"}, 32'(ctl.burst_idx), 32'd0);
    chk({tag, "_pn"}, 32'(ctl.prbs_pn_select_out), 32'd0);
    chk({tag, "_bit_rate"}, ctl.prbs_bit_rate_out, 32'd0);
    chk({tag, "_edge"}, 32'(ctl.prbs_edge_time_out), 32'd0);
  endtask

  int n_rs;
  int n_low;
  int n_bad;
  int n_done;
  logic seen;

  initial begin
    reset                     = 1'b1;
    ctl.cfg_wr                = 1'b0;
    ctl.cfg_pn_select         = '0;
    ctl.cfg_bit_rate          = '0;
    ctl.cfg_edge_time         = '0;
    ctl.burst_len             = '0;
    ctl.gap_len               = '0;
    ctl.burst_total           = '0;
    ctl.reseed_each           = 1'b0;
    ctl.start                 = 1'b0;
    ctl.stop                  = 1'b0;
    ctl.fault_clr             = 1'b0;
    ctl.CH_LOAD_PROTECT_STATE = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values("reset");
    step();
    reset = 1'b0;

    // Config commit on start and continuous output.
    do_cfg(PN_15, 32'h55, 8'h12);
    @(negedge clk);
    chk("cfg_pending_set", 32'(ctl.cfg_pending), 32'd1);
    chk("cfg_not_active_yet", 32'(ctl.prbs_pn_select_out), 32'd0);
    do_start();
    n_rs  = 0;
    n_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ctl.state != ST_RESEED) break;
      n_rs++;
      if (!ctl.core_reset_n) n_low++;
    end
    chk("reseed_cycles", 32'(n_rs), 32'd4);
    chk("reseed_core_low", 32'(n_low), 32'd4);
    chk("run_state", 32'(ctl.state), 32'(ST_RUN));
    chk("run_core_reset_n", 32'(ctl.core_reset_n), 32'd1);
    chk("run_pn", 32'(ctl.prbs_pn_select_out), 32'd3);
    chk("run_bit_rate", ctl.prbs_bit_rate_out, 32'h55);
    chk("run_edge", 32'(ctl.prbs_edge_time_out), 32'h12);
    chk("run_pending_clr", 32'(ctl.cfg_pending), 32'd0);
    n_bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (!ctl.output_enable || (ctl.state != ST_RUN)) n_bad++;
    end
    chk("continuous_oe", 32'(n_bad), 32'd0);
    do_stop();
    @(negedge clk);
    chk("stop_state", 32'(ctl.state), 32'(ST_IDLE));
    chk("stop_oe", 32'(ctl.output_enable), 32'd0);
    chk("stop_core_reset_n", 32'(ctl.core_reset_n), 32'd0);

    // Three bursts of 8 ticks with 4-tick gaps.
    ctl.burst_len   = 32'd8;
    ctl.gap_len     = 32'd4;
    ctl.burst_total = 16'd3;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, BURST_W'(b)});
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, BURST_W'(b)});
    end
    mon_en = 1'b1;
    do_start();
    n_done = 0;
    seen   = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ctl.done) n_done++;
      if (ctl.state == ST_DONE) seen = 1'b1;
    end
    repeat (5) begin
      @(negedge clk);
      if (ctl.done) n_done++;
    end
    mon_en = 1'b0;
    chk("burst_done_pulses", 32'(n_done), 32'd1);
    chk("burst_final_state", 32'(ctl.state), 32'(ST_DONE));
    chk("burst_final_idx", 32'(ctl.burst_idx), 32'd2);
    chk("burst_final_oe", 32'(ctl.output_enable), 32'd0);
    chk("burst_final_core", 32'(ctl.core_reset_n), 32'd0);
    chk("burst_final_busy", 32'(ctl.busy), 32'd0);
    chk("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mid-run config write is held until the burst boundary.
    ctl.burst_len   = 32'd8;
    ctl.gap_len     = 32'd2;
    ctl.burst_total = 16'd0;
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, BURST_W'(0)});
    for (int i = 0; i < 2; i++) exp_q.push_back({1'b0, BURST_W'(0)});
    mon_en = 1'b1;
    do_start();
    wait_state(ST_RUN, 20, "midcfg_run");
    do_cfg(PN_15, 32'h100, 8'h12);
    @(negedge clk);
    chk("midcfg_pending", 32'(ctl.cfg_pending), 32'd1);
    chk("midcfg_rate_held", ctl.prbs_bit_rate_out, 32'h55);
    n_bad = 0;
    seen  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ctl.state == ST_RESEED) break;
      if (ctl.prbs_bit_rate_out != 32'h55) n_bad++;
      if (ctl.state == ST_GAP) seen = 1'b1;
    end
    mon_en = 1'b0;
    chk("midcfg_reseed", 32'(ctl.state), 32'(ST_RESEED));
    chk("midcfg_no_early_commit", 32'(n_bad), 32'd0);
    chk("midcfg_gap_seen", 32'(seen), 32'd1);
    chk("midcfg_rate_new", ctl.prbs_bit_rate_out, 32'h100);
    chk("midcfg_pending_clr", 32'(ctl.cfg_pending), 32'd0);
    chk("midcfg_idx", 32'(ctl.burst_idx), 32'd1);
    chk("midcfg_core_low", 32'(ctl.core_reset_n), 32'd0);
    chk("midcfg_queue_empty", 32'(exp_q.size()), 32'd0);
    do_stop();
    @(negedge clk);
    chk("stop_idx_held", 32'(ctl.burst_idx), 32'd1);

    // Protection latches a fault; clear only when protection is low.
    ctl.burst_len = 32'd0;
    do_start();
    wait_state(ST_RUN, 20, "prot_run");
    step();
    ctl.CH_LOAD_PROTECT_STATE = 1'b1;
    step();
    @(negedge clk);
    chk("prot_state", 32'(ctl.state), 32'(ST_FAULT));
    chk("prot_oe", 32'(ctl.output_enable), 32'd0);
    chk("prot_fault", 32'(ctl.fault), 32'd1);
    chk("prot_core", 32'(ctl.core_reset_n), 32'd0);
    chk("prot_busy", 32'(ctl.busy), 32'd0);
    do_fault_clr();
    @(negedge clk);
    chk("prot_clr_ignored", 32'(ctl.state), 32'(ST_FAULT));
    step();
    ctl.CH_LOAD_PROTECT_STATE = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("prot_latched", 32'(ctl.fault), 32'd1);
    do_fault_clr();
    @(negedge clk);
    chk("prot_clr_state", 32'(ctl.state), 32'(ST_IDLE));
    chk("prot_clr_fault", 32'(ctl.fault), 32'd0);

    // Simultaneous start+stop, then protect+stop.
    step();
    ctl.start = 1'b1;
    ctl.stop  = 1'b1;
    step();
    ctl.start = 1'b0;
    ctl.stop  = 1'b0;
    @(negedge clk);
    chk("start_stop_idle", 32'(ctl.state), 32'(ST_IDLE));
    chk("start_stop_busy", 32'(ctl.busy), 32'd0);
    do_start();
    wait_state(ST_RUN, 20, "ps_run");
    step();
    ctl.CH_LOAD_PROTECT_STATE = 1'b1;
    ctl.stop                  = 1'b1;
    step();
    ctl.stop = 1'b0;
    @(negedge clk);
    chk("prot_stop_fault", 32'(ctl.state), 32'(ST_FAULT));
    step();
    ctl.CH_LOAD_PROTECT_STATE = 1'b0;
    do_fault_clr();
    @(negedge clk);
    chk("prot_stop_clr", 32'(ctl.state), 32'(ST_IDLE));

    // cfg_wr together with start writes straight through to active.
    step();
    ctl.cfg_wr        = 1'b1;
    ctl.cfg_pn_select = PN_23;
    ctl.start         = 1'b1;
    step();
    ctl.cfg_wr = 1'b0;
    ctl.start  = 1'b0;
    @(negedge clk);
    chk("wt_pn", 32'(ctl.prbs_pn_select_out), 32'd5);
    chk("wt_pending", 32'(ctl.cfg_pending), 32'd0);
    chk("wt_state", 32'(ctl.state), 32'(ST_RESEED));
    do_stop();

    // Asynchronous reset while in GAP.
    ctl.burst_len   = 32'd8;
    ctl.gap_len     = 32'd40;
    ctl.burst_total = 16'd0;
    do_start();
    wait_state(ST_RUN, 20, "ar_run");
    do_cfg(4'd9, 32'h77, 8'h33);
    wait_state(ST_GAP, 200, "ar_gap");
    chk("ar_gap_pending", 32'(ctl.cfg_pending), 32'd1);
    chk("ar_gap_oe", 32'(ctl.output_enable), 32'd0);
    chk("ar_gap_core", 32'(ctl.core_reset_n), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_values("async");
    step();
    reset = 1'b0;
    do_start();
    @(negedge clk);
    chk("ar_staging_lost", 32'(ctl.prbs_pn_select_out), 32'd0);
    chk("ar_restart_state", 32'(ctl.state), 32'(ST_RESEED));
    do_stop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
